// File: rtl/frame_stream_ctrl.sv
// Frame sequencer. It reads one frame from the source RAM and feeds it to the processing
// core, then writes every core output pulse into the destination RAM at sequential addresses.
module frame_stream_ctrl #(
  parameter int PIXELS = 76800,
  parameter int AW     = 17,
  parameter int DW     = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          ovf_o,
  output logic          src_en_o,
  output logic [AW-1:0] src_addr_o,
  input  logic [DW-1:0] src_data_i,
  output logic          core_en_o,
  output logic [DW-1:0] core_data_o,
  output logic          core_valid_o,
  input  logic          core_ready_i,
  input  logic [DW-1:0] core_data_i,
  input  logic          core_valid_i,
  output logic          dst_en_o,
  output logic          dst_we_o,
  output logic [AW-1:0] dst_addr_o,
  output logic [DW-1:0] dst_data_o,
  output logic [2:0]    dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_WAIT  = 3'd2,
    S_SEND  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // One spare counter bit keeps a count of PIXELS representable even when PIXELS == 2**AW.
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST_PIX = CW'(PIXELS - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(PIXELS);

  state_t        state_q, state_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          src_en_q, src_en_d;
  logic [AW-1:0] src_addr_q, src_addr_d;
  logic [DW-1:0] core_data_q, core_data_d;
  logic          core_valid_q, core_valid_d;
  logic          dst_wr_q, dst_wr_d;
  logic [AW-1:0] dst_addr_q, dst_addr_d;
  logic [DW-1:0] dst_data_q, dst_data_d;
  logic          capture;

  // Handshake: core_valid_o holds with core_data_o stable until a cycle where core_ready_i is
  // also high; that cycle transfers the pixel and core_valid_o drops on the following cycle.
  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    ovf_d       = ovf_q;
    core_data_d = core_data_q;
    dst_wr_d    = 1'b0;
    dst_addr_d  = dst_addr_q;
    dst_data_d  = dst_data_q;
    capture     = (state_q == S_RD) || (state_q == S_WAIT) ||
                  (state_q == S_SEND) || (state_q == S_DRAIN);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d   = S_RD;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          ovf_d     = 1'b0;
        end
      end
      S_RD:   state_d = S_WAIT;
      S_WAIT: begin
        core_data_d = src_data_i;
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (core_ready_i) begin
          in_cnt_d = in_cnt_q + CW'(1);
          state_d  = (in_cnt_q == LAST_PIX) ? S_DRAIN : S_RD;
        end
      end
      S_DRAIN: begin
        if (out_cnt_q == FULL_CNT) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Core output has no backpressure, so every pulse is written or flagged as overflow.
    if (capture && core_valid_i) begin
      if (out_cnt_q < FULL_CNT) begin
        dst_wr_d   = 1'b1;
        dst_addr_d = out_cnt_q[AW-1:0];
        dst_data_d = core_data_i;
        out_cnt_d  = out_cnt_q + CW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end

    busy_d       = (state_d == S_RD) || (state_d == S_WAIT) ||
                   (state_d == S_SEND) || (state_d == S_DRAIN);
    done_d       = (state_d == S_DONE);
    src_en_d     = (state_d == S_RD);
    src_addr_d   = (state_d == S_RD) ? in_cnt_d[AW-1:0] : src_addr_q;
    core_valid_d = (state_d == S_SEND);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      src_en_q     <= 1'b0;
      src_addr_q   <= '0;
      core_data_q  <= '0;
      core_valid_q <= 1'b0;
      dst_wr_q     <= 1'b0;
      dst_addr_q   <= '0;
      dst_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      src_en_q     <= src_en_d;
      src_addr_q   <= src_addr_d;
      core_data_q  <= core_data_d;
      core_valid_q <= core_valid_d;
      dst_wr_q     <= dst_wr_d;
      dst_addr_q   <= dst_addr_d;
      dst_data_q   <= dst_data_d;
    end
  end

  assign busy_o       = busy_q;
  assign core_en_o    = busy_q;
  assign done_o       = done_q;
  assign ovf_o        = ovf_q;
  assign src_en_o     = src_en_q;
  assign src_addr_o   = src_addr_q;
  assign core_data_o  = core_data_q;
  assign core_valid_o = core_valid_q;
  assign dst_en_o     = dst_wr_q;
  assign dst_we_o     = dst_wr_q;
  assign dst_addr_o   = dst_addr_q;
  assign dst_data_o   = dst_data_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_frame_stream_ctrl.sv
// Directed bench for frame_stream_ctrl: a 4-pixel instance for the handshake, capture, overflow
// and reset scenarios, and a 1024-pixel instance for a whole-frame RAM-to-RAM comparison.
module tb_frame_stream_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- small instance: PIXELS=4, AW=3 ----------------
  logic       s_start, s_busy, s_done, s_ovf, s_src_en, s_core_en;
  logic [2:0] s_src_addr, s_dst_addr, s_state;
  logic [7:0] s_src_data, s_core_data_o, s_core_data_i, s_dst_data;
  logic       s_core_valid_o, s_ready, s_core_valid_i, s_dst_en, s_dst_we;
  logic       echo_en, man_valid;
  logic [7:0] man_data;
  logic [7:0] s_src_mem [0:7];
  logic       s_p1_v, s_p2_v;
  logic [7:0] s_p1_d, s_p2_d;

  frame_stream_ctrl #(.PIXELS(4), .AW(3), .DW(8)) u_small (
    .clk_i(clk), .rst_i(rst), .start_i(s_start), .busy_o(s_busy), .done_o(s_done),
    .ovf_o(s_ovf), .src_en_o(s_src_en), .src_addr_o(s_src_addr), .src_data_i(s_src_data),
    .core_en_o(s_core_en), .core_data_o(s_core_data_o), .core_valid_o(s_core_valid_o),
    .core_ready_i(s_ready), .core_data_i(s_core_data_i), .core_valid_i(s_core_valid_i),
    .dst_en_o(s_dst_en), .dst_we_o(s_dst_we), .dst_addr_o(s_dst_addr),
    .dst_data_o(s_dst_data), .dbg_state_o(s_state)
  );

  // Source RAM with one-cycle read latency and a core that echoes each accepted pixel 2 cycles later.
  always @(posedge clk) begin
    if (s_src_en) s_src_data <= s_src_mem[s_src_addr];
    s_p1_v <= s_core_valid_o && s_ready;
    s_p1_d <= s_core_data_o;
    s_p2_v <= s_p1_v;
    s_p2_d <= s_p1_d;
  end
  assign s_core_valid_i = echo_en ? s_p2_v : man_valid;
  assign s_core_data_i  = echo_en ? s_p2_d : man_data;

  int         rd_addr_log [$];
  logic [7:0] hs_log [$];
  int         wr_addr_log [$];
  logic [7:0] wr_data_log [$];
  int         wr_cyc_log [$];
  logic [7:0] exp_q [$];

  always @(negedge clk) begin
    if (s_src_en === 1'b1) rd_addr_log.push_back(int'(s_src_addr));
    if (s_core_valid_o === 1'b1 && s_ready === 1'b1) hs_log.push_back(s_core_data_o);
    if (s_dst_en === 1'b1 && s_dst_we === 1'b1) begin
      wr_addr_log.push_back(int'(s_dst_addr));
      wr_data_log.push_back(s_dst_data);
      wr_cyc_log.push_back(cyc);
    end
  end

  // ---------------- full-frame instance: PIXELS=1024, AW=10 ----------------
  logic       b_start, b_busy, b_done, b_ovf, b_src_en, b_core_en, b_ready;
  logic [9:0] b_src_addr, b_dst_addr;
  logic [7:0] b_src_data, b_core_data_o, b_core_data_i, b_dst_data;
  logic       b_core_valid_o, b_core_valid_i, b_dst_en, b_dst_we;
  logic [2:0] b_state;
  logic [7:0] b_src_mem [0:1023];
  logic [7:0] b_dst_mem [0:1023];
  logic       b_p1_v, b_p2_v;
  logic [7:0] b_p1_d, b_p2_d;
  int         b_wr_cnt = 0;

  frame_stream_ctrl #(.PIXELS(1024), .AW(10), .DW(8)) u_big (
    .clk_i(clk), .rst_i(rst), .start_i(b_start), .busy_o(b_busy), .done_o(b_done),
    .ovf_o(b_ovf), .src_en_o(b_src_en), .src_addr_o(b_src_addr), .src_data_i(b_src_data),
    .core_en_o(b_core_en), .core_data_o(b_core_data_o), .core_valid_o(b_core_valid_o),
    .core_ready_i(b_ready), .core_data_i(b_core_data_i), .core_valid_i(b_core_valid_i),
    .dst_en_o(b_dst_en), .dst_we_o(b_dst_we), .dst_addr_o(b_dst_addr),
    .dst_data_o(b_dst_data), .dbg_state_o(b_state)
  );

  always @(posedge clk) begin
    if (b_src_en) b_src_data <= b_src_mem[b_src_addr];
    if (b_dst_en && b_dst_we) begin
      b_dst_mem[b_dst_addr] <= b_dst_data;
      b_wr_cnt <= b_wr_cnt + 1;
    end
    b_p1_v <= b_core_valid_o && b_ready;
    b_p1_d <= b_core_data_o;
    b_p2_v <= b_p1_v;
    b_p2_d <= b_p1_d;
  end
  assign b_core_valid_i = b_p2_v;
  assign b_core_data_i  = b_p2_d;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_addr_log.delete();
    hs_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    wr_cyc_log.delete();
    exp_q.delete();
  endtask

  task automatic wait_s_done(input string tag, input int budget);
    int n = 0;
    while (s_done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, s_done, 1);
  endtask

  task automatic wait_s_rd(input string tag, input logic [2:0] addr);
    int n = 0;
    while (!(s_src_en === 1'b1 && s_src_addr === addr) && n < 50) begin
      tick();
      n++;
    end
    check(tag, s_src_en && (s_src_addr == addr), 1);
  endtask

  task automatic wait_s_valid(input string tag);
    int n = 0;
    while (s_core_valid_o !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check(tag, s_core_valid_o, 1);
  endtask

  task automatic verify_feed(input string tag);
    check({tag, "_rd_n"}, rd_addr_log.size(), 4);
    for (int i = 0; i < rd_addr_log.size() && i < 4; i++)
      check($sformatf("%s_rd%0d", tag, i), rd_addr_log[i], i);
    check({tag, "_hs_n"}, hs_log.size(), 4);
    for (int i = 0; i < hs_log.size() && i < 4; i++)
      check($sformatf("%s_hs%0d", tag, i), hs_log[i], s_src_mem[i]);
  endtask

  task automatic verify_writes(input string tag);
    int i = 0;
    check({tag, "_wr_n"}, wr_addr_log.size(), exp_q.size());
    while (exp_q.size() > 0 && wr_addr_log.size() > 0) begin
      check($sformatf("%s_wa%0d", tag, i), wr_addr_log.pop_front(), i);
      check($sformatf("%s_wd%0d", tag, i), wr_data_log.pop_front(), exp_q.pop_front());
      i++;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int done_cyc, last_wr, errs, n;
    rst = 1'b1;
    s_start = 1'b0;
    s_ready = 1'b1;
    echo_en = 1'b1;
    man_valid = 1'b0;
    man_data = 8'h00;
    b_start = 1'b0;
    b_ready = 1'b1;
    for (int i = 0; i < 8; i++) s_src_mem[i] = 8'h00;
    s_src_mem[0] = 8'd10;
    s_src_mem[1] = 8'd20;
    s_src_mem[2] = 8'd30;
    s_src_mem[3] = 8'd40;
    for (int i = 0; i < 1024; i++) b_src_mem[i] = 8'($urandom_range(0, 255));

    repeat (3) tick();
    check("reset_outputs", {s_busy, s_done, s_ovf, s_src_en, s_src_addr, s_core_en,
          s_core_data_o, s_core_valid_o, s_dst_en, s_dst_we, s_dst_addr, s_dst_data, s_state}, 0);
    rst = 1'b0;
    tick();

    // Basic frame: ready tied high, core echoes after 2 cycles.
    clear_logs();
    exp_q = '{8'd10, 8'd20, 8'd30, 8'd40};
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    check("t1_first_rd", {s_busy, s_core_en, s_src_en, s_src_addr, s_done}, {1'b1, 1'b1, 1'b1, 3'd0, 1'b0});
    wait_s_done("t1_done", 100);
    done_cyc = cyc;
    last_wr = (wr_cyc_log.size() > 0) ? wr_cyc_log[$] : -100;
    check("t1_done_after_last_wr", done_cyc - last_wr, 1);
    check("t1_idle_flags", {s_busy, s_core_en, s_ovf}, 0);
    verify_feed("t1");
    verify_writes("t1");

    // Pulses while DONE are ignored.
    clear_logs();
    echo_en = 1'b0;
    man_valid = 1'b1;
    man_data = 8'h55;
    tick();
    man_valid = 1'b0;
    tick();
    check("done_pulse_no_write", wr_addr_log.size(), 0);
    check("done_pulse_flags", {s_done, s_ovf}, {1'b1, 1'b0});

    // Backpressure on pixel 2; start from DONE.
    clear_logs();
    echo_en = 1'b1;
    exp_q = '{8'd10, 8'd20, 8'd30, 8'd40};
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    check("t2_restart", {s_done, s_busy}, {1'b0, 1'b1});
    wait_s_rd("t2_rd2_seen", 3'd2);
    s_ready = 1'b0;
    wait_s_valid("t2_valid_seen");
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_hold%0d", i), {s_core_valid_o, s_core_data_o, s_state, s_src_en},
            {1'b1, 8'd30, 3'd3, 1'b0});
      tick();
    end
    s_ready = 1'b1;
    wait_s_done("t2_done", 100);
    verify_feed("t2");
    verify_writes("t2");

    // Back-to-back pulses, then a fifth pulse once the frame is full.
    clear_logs();
    echo_en = 1'b0;
    exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      man_valid = 1'b1;
      man_data = 8'hA1 + 8'(i);
      tick();
    end
    man_valid = 1'b0;
    tick();
    man_valid = 1'b1;
    man_data = 8'hEE;
    tick();
    man_valid = 1'b0;
    check("t4_ovf_set", {s_ovf, s_busy}, {1'b1, 1'b1});
    wait_s_done("t4_done", 100);
    check("t4_ovf_sticky", s_ovf, 1);
    n = (wr_cyc_log.size() == 4) ? (wr_cyc_log[3] - wr_cyc_log[0]) : -1;
    check("t3_b2b_span", n, 3);
    verify_writes("t3");

    // Next start clears ovf; then reset while parked in SEND on pixel 2.
    clear_logs();
    echo_en = 1'b1;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    check("t4_ovf_cleared", {s_ovf, s_done, s_busy}, {1'b0, 1'b0, 1'b1});
    wait_s_rd("t5_rd2_seen", 3'd2);
    s_ready = 1'b0;
    wait_s_valid("t5_valid_seen");
    check("t5_in_send", {s_state, s_core_data_o}, {3'd3, 8'd30});
    rst = 1'b1;
    tick();
    check("t5_reset_outputs", {s_busy, s_done, s_ovf, s_src_en, s_src_addr, s_core_en,
          s_core_data_o, s_core_valid_o, s_dst_en, s_dst_we, s_dst_addr, s_dst_data, s_state}, 0);
    rst = 1'b0;
    s_ready = 1'b1;
    clear_logs();
    repeat (4) tick();
    check("t5_quiet_after_reset", {rd_addr_log.size(), wr_addr_log.size(), 1'b0, s_busy, s_state},
          0);
    exp_q = '{8'd10, 8'd20, 8'd30, 8'd40};
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    wait_s_done("t5_rerun_done", 100);
    verify_feed("t5");
    verify_writes("t5");

    // Whole frame on the 1024-pixel instance.
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    n = 0;
    while (b_done !== 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    check("full_done", b_done, 1);
    check("full_flags", {b_busy, b_ovf, b_core_en}, 0);
    check("full_wr_count", b_wr_cnt, 1024);
    errs = 0;
    for (int i = 0; i < 1024; i++)
      if (b_dst_mem[i] !== b_src_mem[i]) errs++;
    check("full_ram_mismatches", errs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
